// File: rtl/cga_tty_writer_if.sv
// Byte-stream handshake into the CGA teletype writer.
// The console drives the master side and the writer takes the slave side.
interface cga_tty_writer_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [7:0] attr;
   logic       clear;

   modport master (output in_valid, output in_data, output attr, output clear, input in_ready);
   modport slave  (input in_valid, input in_data, input attr, input clear, output in_ready);
endinterface

// File: rtl/cga_tty_writer.sv
// Teletype-style writer into the 80x25 CGA text RAM: prints bytes at the cursor,
// handles CR/LF/BS, scrolls the screen up by one row and clears the screen.
module cga_tty_writer #(
   parameter int unsigned COLS     = 80,
   parameter int unsigned ROWS     = 25,
   parameter int unsigned ADDR_W   = 12,
   parameter logic [7:0]  DEF_ATTR = 8'h07
) (
   input  logic                clock_25,
   input  logic                reset_n,
   cga_tty_writer_if.slave     tty,
   output logic [ADDR_W-1:0]   vram_address,
   output logic [15:0]         vram_wdata,
   output logic                vram_we,
   input  logic [15:0]         vram_rdata,
   output logic [6:0]          cursor_x,
   output logic [4:0]          cursor_y,
   output logic                busy
);

   localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(COLS * ROWS - 1);
   localparam logic [ADDR_W-1:0] LAST_SCROLL   = ADDR_W'((ROWS - 1) * COLS - 1);
   localparam logic [ADDR_W-1:0] LAST_COL_IDX  = ADDR_W'(COLS - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
   localparam logic [ADDR_W-1:0] ROW_STRIDE    = ADDR_W'(COLS);
   localparam logic [6:0]        MAX_X         = 7'(COLS - 1);
   localparam logic [4:0]        MAX_Y         = 5'(ROWS - 1);
   localparam logic [7:0]        CH_CR         = 8'h0D;
   localparam logic [7:0]        CH_LF         = 8'h0A;
   localparam logic [7:0]        CH_BS         = 8'h08;
   localparam logic [7:0]        CH_SPACE      = 8'h20;

   typedef enum logic [2:0] {
      S_CLEAR_ALL,
      S_IDLE,
      S_PUT,
      S_SCROLL_RD,
      S_SCROLL_WR,
      S_CLEAR_LINE
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   idx;
   logic [7:0]          attr_q;
   logic [7:0]          char_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [15:0]         wdata_q;
   logic                pass_q;
   logic [ADDR_W-1:0]   cell_addr;

   assign tty.in_ready = (state == S_IDLE) && !tty.clear;
   assign cell_addr    = ADDR_W'(cursor_y) * ROW_STRIDE + ADDR_W'(cursor_x);

   // Scroll writes land the cycle the read data returns, so the data word bypasses the register.
   assign vram_we      = we_q;
   assign vram_address = addr_q;
   assign vram_wdata   = pass_q ? vram_rdata : wdata_q;
   assign busy         = (state != S_IDLE);

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_CLEAR_ALL;
         idx      <= '0;
         attr_q   <= DEF_ATTR;
         char_q   <= '0;
         cursor_x <= '0;
         cursor_y <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         pass_q   <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         pass_q <= 1'b0;
         case (state)
            S_CLEAR_ALL: begin
               we_q    <= 1'b1;
               addr_q  <= idx;
               wdata_q <= {attr_q, CH_SPACE};
               if (idx == LAST_CELL) begin
                  idx      <= '0;
                  cursor_x <= '0;
                  cursor_y <= '0;
                  state    <= S_IDLE;
               end else begin
                  idx <= idx + ADDR_W'(1);
               end
            end
            S_IDLE: begin
               if (tty.clear) begin
                  attr_q <= tty.attr;
                  idx    <= '0;
                  state  <= S_CLEAR_ALL;
               end else if (tty.in_valid) begin
                  char_q <= tty.in_data;
                  attr_q <= tty.attr;
                  state  <= S_PUT;
               end
            end
            S_PUT: begin
               state <= S_IDLE;
               case (char_q)
                  CH_CR: cursor_x <= '0;
                  CH_LF: begin
                     if (cursor_y < MAX_Y) begin
                        cursor_y <= cursor_y + 5'd1;
                     end else begin
                        idx   <= '0;
                        state <= S_SCROLL_RD;
                     end
                  end
                  CH_BS: begin
                     if (cursor_x != '0) cursor_x <= cursor_x - 7'd1;
                  end
                  default: begin
                     we_q    <= 1'b1;
                     addr_q  <= cell_addr;
                     wdata_q <= {attr_q, char_q};
                     if (cursor_x < MAX_X) begin
                        cursor_x <= cursor_x + 7'd1;
                     end else begin
                        cursor_x <= '0;
                        if (cursor_y < MAX_Y) begin
                           cursor_y <= cursor_y + 5'd1;
                        end else begin
                           idx   <= '0;
                           state <= S_SCROLL_RD;
                        end
                     end
                  end
               endcase
            end
            S_SCROLL_RD: begin
               addr_q <= idx + ROW_STRIDE;
               state  <= S_SCROLL_WR;
            end
            S_SCROLL_WR: begin
               we_q   <= 1'b1;
               addr_q <= idx;
               pass_q <= 1'b1;
               if (idx == LAST_SCROLL) begin
                  idx   <= '0;
                  state <= S_CLEAR_LINE;
               end else begin
                  idx   <= idx + ADDR_W'(1);
                  state <= S_SCROLL_RD;
               end
            end
            S_CLEAR_LINE: begin
               we_q    <= 1'b1;
               addr_q  <= LAST_ROW_BASE + idx;
               wdata_q <= {attr_q, CH_SPACE};
               if (idx == LAST_COL_IDX) begin
                  idx      <= '0;
                  cursor_y <= MAX_Y;
                  state    <= S_IDLE;
               end else begin
                  idx <= idx + ADDR_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cga_tty_writer.sv
// Directed bench for cga_tty_writer with a behavioural text RAM (1-cycle read latency).
module tb_cga_tty_writer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] vram_address;
   logic [15:0] vram_wdata;
   logic        vram_we;
   logic [15:0] vram_rdata;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        busy;

   cga_tty_writer_if tty ();

   cga_tty_writer dut (
      .clock_25     (clk),
      .reset_n      (rst_n),
      .tty          (tty.slave),
      .vram_address (vram_address),
      .vram_wdata   (vram_wdata),
      .vram_we      (vram_we),
      .vram_rdata   (vram_rdata),
      .cursor_x     (cursor_x),
      .cursor_y     (cursor_y),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [4096];
   logic [15:0] snap [2000];
   int          wr_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   always @(posedge clk) begin
      if (vram_we) begin
         mem[vram_address] <= vram_wdata;
         wr_cnt = wr_cnt + 1;
      end
      vram_rdata <= mem[vram_address];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic settle(input string tag, input int bound);
      int n = 0;
      @(negedge clk);
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < bound), 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic [7:0] a);
      int n = 0;
      @(negedge clk);
      while (!tty.in_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) chk("send_timeout", 32'(n), 32'd0);
      tty.in_valid = 1'b1;
      tty.in_data  = b;
      tty.attr     = a;
      @(posedge clk);
      #1 tty.in_valid = 1'b0;
   endtask

   initial begin
      int base;
      int bad;
      tty.in_valid = 1'b0;
      tty.in_data  = 8'h00;
      tty.attr     = 8'h00;
      tty.clear    = 1'b0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(tty.in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_we", 32'(vram_we), 32'd0);
      chk("rst_cursor", {cursor_y, cursor_x}, 32'd0);

      // Power-up clear
      rst_n = 1'b1;
      settle("clear_all", 2100);
      chk("clear_all_writes", 32'(wr_cnt), 32'd2000);
      bad = 0;
      for (int k = 0; k < 2000; k++) if (mem[k] !== 16'h0720) bad++;
      chk("clear_all_pattern", 32'(bad), 32'd0);
      chk("clear_all_ready", 32'(tty.in_ready), 32'd1);
      chk("clear_all_cursor", {cursor_y, cursor_x}, 32'd0);

      // Single printable byte
      base = wr_cnt;
      send(8'h41, 8'h1E);
      @(negedge clk);
      chk("put_ready_low", 32'(tty.in_ready), 32'd0);
      @(negedge clk);
      chk("put_ready_back", 32'(tty.in_ready), 32'd1);
      chk("put_bus", {vram_we, 3'b0, vram_address, vram_wdata}, {1'b1, 3'b0, 12'd0, 16'h1E41});
      @(posedge clk); #1;
      chk("put_writes", 32'(wr_cnt - base), 32'd1);
      chk("put_mem0", 32'(mem[0]), 32'h1E41);
      chk("put_cursor", {cursor_y, cursor_x}, {20'd0, 5'd0, 7'd1});

      // CR then 3 LF to reach (0,3), no writes
      base = wr_cnt;
      send(8'h0D, 8'h07);
      settle("cr", 10);
      chk("cr_cursor", {cursor_y, cursor_x}, {20'd0, 5'd0, 7'd0});
      for (int i = 0; i < 3; i++) send(8'h0A, 8'h07);
      settle("lf3", 10);
      chk("lf_cursor", {cursor_y, cursor_x}, {20'd0, 5'd3, 7'd0});
      chk("ctrl_no_write", 32'(wr_cnt - base), 32'd0);

      // Full row of 'B' wraps to the next row
      base = wr_cnt;
      for (int i = 0; i < 80; i++) send(8'h42, 8'h07);
      settle("row", 10);
      chk("row_writes", 32'(wr_cnt - base), 32'd80);
      chk("row_mem319", 32'(mem[319]), 32'h0742);
      chk("row_mem240", 32'(mem[240]), 32'h0742);
      chk("row_mem320", 32'(mem[320]), 32'h0720);
      chk("row_cursor", {cursor_y, cursor_x}, {20'd0, 5'd4, 7'd0});

      // BS at column 0, then BS at column 7
      base = wr_cnt;
      send(8'h08, 8'h07);
      settle("bs0", 10);
      chk("bs0_cursor", {cursor_y, cursor_x}, {20'd0, 5'd4, 7'd0});
      for (int i = 0; i < 7; i++) send(8'h43, 8'h07);
      send(8'h08, 8'h07);
      settle("bs7", 10);
      chk("bs7_cursor", {cursor_y, cursor_x}, {20'd0, 5'd4, 7'd6});
      chk("bs_writes", 32'(wr_cnt - base), 32'd7);

      // Move to (5,24) and scroll with LF
      send(8'h0D, 8'h07);
      for (int i = 0; i < 20; i++) send(8'h0A, 8'h07);
      for (int i = 0; i < 5; i++) send(8'h44, 8'h07);
      settle("pre_scroll", 10);
      chk("pre_scroll_cursor", {cursor_y, cursor_x}, {20'd0, 5'd24, 7'd5});
      for (int k = 0; k < 2000; k++) snap[k] = mem[k];
      base = wr_cnt;
      send(8'h0A, 8'h2F);
      settle("scroll", 5000);
      bad = 0;
      for (int k = 0; k < 1920; k++) if (mem[k] !== snap[k + 80]) bad++;
      chk("scroll_shift", 32'(bad), 32'd0);
      bad = 0;
      for (int k = 1920; k < 2000; k++) if (mem[k] !== 16'h2F20) bad++;
      chk("scroll_blank", 32'(bad), 32'd0);
      chk("scroll_mem239", 32'(mem[239]), 32'h0742);
      chk("scroll_mem240", 32'(mem[240]), 32'h0743);
      chk("scroll_mem1840", 32'(mem[1840]), 32'h0744);
      chk("scroll_writes", 32'(wr_cnt - base), 32'd2000);
      chk("scroll_cursor", {cursor_y, cursor_x}, {20'd0, 5'd24, 7'd5});

      // clear and in_valid together: clear wins
      base = wr_cnt;
      @(negedge clk);
      tty.clear    = 1'b1;
      tty.in_valid = 1'b1;
      tty.in_data  = 8'h5A;
      tty.attr     = 8'h4E;
      #1 chk("clr_in_ready", 32'(tty.in_ready), 32'd0);
      @(posedge clk);
      #1;
      tty.clear    = 1'b0;
      tty.in_valid = 1'b0;
      chk("clr_busy", 32'(busy), 32'd1);
      settle("clr", 2100);
      chk("clr_writes", 32'(wr_cnt - base), 32'd2000);
      bad = 0;
      for (int k = 0; k < 2000; k++) if (mem[k] !== 16'h4E20) bad++;
      chk("clr_pattern", 32'(bad), 32'd0);
      chk("clr_cursor", {cursor_y, cursor_x}, 32'd0);
      send(8'h5A, 8'h4E);
      settle("after_clr", 10);
      chk("after_clr_mem0", 32'(mem[0]), 32'h4E5A);
      chk("after_clr_cursor", {cursor_y, cursor_x}, {20'd0, 5'd0, 7'd1});

      // clear pulsed during a scroll is ignored
      send(8'h0D, 8'h07);
      for (int i = 0; i < 24; i++) send(8'h0A, 8'h07);
      settle("pre_scroll2", 10);
      chk("pre_scroll2_cursor", {cursor_y, cursor_x}, {20'd0, 5'd24, 7'd0});
      base = wr_cnt;
      send(8'h0A, 8'h07);
      repeat (10) @(negedge clk);
      tty.clear = 1'b1;
      tty.attr  = 8'h11;
      repeat (3) @(negedge clk);
      chk("scroll_clr_ready", 32'(tty.in_ready), 32'd0);
      tty.clear = 1'b0;
      settle("scroll2", 5000);
      chk("scroll2_writes", 32'(wr_cnt - base), 32'd2000);
      chk("scroll2_mem0", 32'(mem[0]), 32'h4E20);
      chk("scroll2_mem1919", 32'(mem[1919]), 32'h4E20);
      chk("scroll2_mem1999", 32'(mem[1999]), 32'h0720);
      bad = 0;
      for (int k = 0; k < 2000; k++) if (mem[k] === 16'h1120) bad++;
      chk("scroll2_no_clear", 32'(bad), 32'd0);
      chk("scroll2_cursor", {cursor_y, cursor_x}, {20'd0, 5'd24, 7'd0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
